// File: rtl/reader_tx_ser.sv
// reader_tx_ser: buffers words from the reader controller in a small FIFO,
// frames them with a preamble and EOF, and line-encodes them onto TX_R as
// NRZ, Manchester or FM0 at a half-bit period of HB_BASE << rate_sel cycles.
module reader_tx_ser #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int HB_BASE    = 4,
   parameter int PRE_BITS   = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              ack,
   input  logic [1:0]        rate_sel,
   input  logic [1:0]        mode,
   output logic              TX_R,
   output logic              tx_busy,
   output logic              frame_eof,
   output logic              underrun
);

   localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW   = AW + 1;
   localparam int HB_W = $clog2(HB_BASE * 8);
   localparam int MAXB = (DATA_W > PRE_BITS) ? ((DATA_W > 4) ? DATA_W : 4)
                                             : ((PRE_BITS > 4) ? PRE_BITS : 4);
   localparam int BW   = $clog2(MAXB);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_EOF} state_t;

   // FIFO storage and bookkeeping
   logic [DATA_W:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       count_q;
   logic                wr_fire;
   logic                pop;
   logic [DATA_W-1:0]   head_data;
   logic                head_last;

   // Serializer state
   state_t              state_q, state_d;
   logic [HB_W-1:0]     cnt_q, cnt_d;
   logic                half_q, half_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                last_q, last_d;
   logic [1:0]          mode_q, mode_d;
   logic [1:0]          rate_q, rate_d;
   logic                fm0_q, fm0_d;
   logic                tx_q, tx_d;
   logic                underrun_q, underrun_d;

   // Combinational helpers
   logic                hb_tick;
   logic                cur_bit;
   logic                nxt_bit;
   logic                go_eof;

   // Half-bit period minus one, for the half-bit down-counter reload.
   function automatic logic [HB_W-1:0] hb_reload(input logic [1:0] r);
      return HB_W'((HB_BASE << r) - 1);
   endfunction

   // Level for one half-bit; lvl is the level at the end of the previous half.
   function automatic logic enc_half(input logic b, input logic second,
                                     input logic [1:0] m, input logic lvl);
      logic v;
      case (m)
         2'b01:   v = second ? ~b : b;
         2'b10:   v = second ? (b ? lvl : ~lvl) : ~lvl;
         default: v = b;
      endcase
      return v;
   endfunction

   assign wr_fire   = wr_en && ack;
   assign ack       = (count_q != CW'(FIFO_DEPTH));
   assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];
   assign head_last = mem_q[rd_ptr_q][DATA_W];
   assign tx_busy   = (state_q != S_IDLE);
   assign TX_R      = tx_q;
   assign underrun  = underrun_q;

   // FIFO array write; contents need no reset because count_q gates validity.
   always_ff @(posedge CLK) begin
      if (wr_fire) mem_q[wr_ptr_q] <= {wr_last, wr_data};
   end

   // FIFO pointers and occupancy; a write and a pop in one cycle cancel out.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(wr_fire) - CW'(pop);
      end
   end

   // Serializer state register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         half_q     <= 1'b0;
         bit_q      <= '0;
         shift_q    <= '0;
         last_q     <= 1'b0;
         mode_q     <= 2'b00;
         rate_q     <= 2'b00;
         fm0_q      <= 1'b0;
         tx_q       <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         half_q     <= half_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         last_q     <= last_d;
         mode_q     <= mode_d;
         rate_q     <= rate_d;
         fm0_q      <= fm0_d;
         tx_q       <= tx_d;
         underrun_q <= underrun_d;
      end
   end

   // Next-state: TX_R only changes on half-bit boundaries (cnt_q == 0).
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      half_d     = half_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      last_d     = last_q;
      mode_d     = mode_q;
      rate_d     = rate_q;
      fm0_d      = fm0_q;
      tx_d       = tx_q;
      underrun_d = underrun_q;
      pop        = 1'b0;
      frame_eof  = 1'b0;
      nxt_bit    = 1'b1;
      go_eof     = 1'b0;
      hb_tick    = (cnt_q == '0);
      cur_bit    = (state_q == S_DATA) ? shift_q[DATA_W-1] : 1'b1;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d    = S_PRE;
               mode_d     = mode;
               rate_d     = rate_sel;
               underrun_d = 1'b0;
               // FM0 level starts from 0 for every frame.
               tx_d       = enc_half(1'b1, 1'b0, mode, 1'b0);
               fm0_d      = tx_d;
               cnt_d      = hb_reload(rate_sel);
               half_d     = 1'b0;
               bit_d      = '0;
            end
         end

         S_PRE, S_DATA: begin
            if (!hb_tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d = hb_reload(rate_q);
               if (!half_q) begin
                  tx_d   = enc_half(cur_bit, 1'b1, mode_q, fm0_q);
                  fm0_d  = tx_d;
                  half_d = 1'b1;
               end else begin
                  half_d = 1'b0;
                  if (state_q == S_PRE) begin
                     if (bit_q == BW'(PRE_BITS - 1)) begin
                        pop     = 1'b1;
                        shift_d = head_data;
                        last_d  = head_last;
                        state_d = S_DATA;
                        bit_d   = '0;
                        nxt_bit = head_data[DATA_W-1];
                     end else begin
                        bit_d   = bit_q + 1'b1;
                     end
                  end else if (bit_q == BW'(DATA_W - 1)) begin
                     if (last_q) begin
                        go_eof = 1'b1;
                     end else if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head_data;
                        last_d  = head_last;
                        bit_d   = '0;
                        nxt_bit = head_data[DATA_W-1];
                     end else begin
                        underrun_d = 1'b1;
                        go_eof     = 1'b1;
                     end
                  end else begin
                     shift_d = shift_q << 1;
                     bit_d   = bit_q + 1'b1;
                     nxt_bit = shift_d[DATA_W-1];
                  end

                  if (go_eof) begin
                     state_d = S_EOF;
                     tx_d    = 1'b0;
                     bit_d   = '0;
                  end else begin
                     tx_d  = enc_half(nxt_bit, 1'b0, mode_q, fm0_q);
                     fm0_d = tx_d;
                  end
               end
            end
         end

         S_EOF: begin
            tx_d = 1'b0;
            if (!hb_tick) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d = hb_reload(rate_q);
               if (bit_q == BW'(3)) begin
                  state_d   = S_IDLE;
                  frame_eof = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_reader_tx_ser.sv
// Bench for reader_tx_ser: a writer process feeds words while a checker
// compares TX_R cycle by cycle against half-bit sequences built from the
// encoding rules.
`timescale 1ns/1ps
module tb_reader_tx_ser;

   localparam int PRE = 2;

   typedef bit hq_t[$];
   typedef logic [8:0] wq_t[$];

   logic       clk = 1'b0;
   logic       RESET = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_last = 1'b0;
   logic       ack;
   logic [1:0] rate_sel = 2'b00;
   logic [1:0] mode = 2'b00;
   logic       tx_r;
   logic       tx_busy;
   logic       frame_eof;
   logic       underrun;

   int checks = 0;
   int errors = 0;
   bit ack_low = 0;

   reader_tx_ser dut (
      .CLK(clk), .RESET(RESET), .wr_en(wr_en), .wr_data(wr_data),
      .wr_last(wr_last), .ack(ack), .rate_sel(rate_sel), .mode(mode),
      .TX_R(tx_r), .tx_busy(tx_busy), .frame_eof(frame_eof),
      .underrun(underrun)
   );

   always #78.125 clk = ~clk;

   initial begin
      #(60000 * 156.25);
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Half-bit levels of a whole frame, from the encoding rules.
   function automatic hq_t model(input wq_t w, input logic [1:0] m);
      hq_t h;
      bit  bits[$];
      bit  lvl;
      bit  b, h1, h2;
      lvl = 0;
      for (int i = 0; i < PRE; i++) bits.push_back(1'b1);
      foreach (w[i]) for (int j = 7; j >= 0; j--) bits.push_back(w[i][j]);
      foreach (bits[i]) begin
         b = bits[i];
         case (m)
            2'b01:   begin h1 = b; h2 = !b; end
            2'b10:   begin h1 = !lvl; h2 = b ? h1 : !h1; end
            default: begin h1 = b; h2 = b; end
         endcase
         lvl = h2;
         h.push_back(h1);
         h.push_back(h2);
      end
      repeat (4) h.push_back(1'b0);
      return h;
   endfunction

   task automatic writer(input wq_t w);
      int i = 0;
      int guard = 0;
      while (i < w.size() && guard < 20000) begin
         @(negedge clk);
         guard++;
         wr_en   = 1'b1;
         wr_data = w[i][7:0];
         wr_last = w[i][8];
         if (ack) i++;
      end
      @(negedge clk);
      wr_en   = 1'b0;
      wr_last = 1'b0;
      checks++;
      if (i != w.size()) begin
         errors++;
         $display("FAIL writer_stall wrote %0d need %0d", i, w.size());
      end
   endtask

   task automatic check_frame(input hq_t hv, input int p, input bit exp_ur,
                              input int exp_idle, input bit scramble,
                              input string name);
      int idle = 0;
      int len;
      bit ok_tx = 1, ok_eof = 1, ok_busy = 1;
      len = hv.size() * p;
      @(negedge clk);
      while (!tx_busy && idle < 2000) begin
         idle++;
         @(negedge clk);
      end
      checks++;
      if (!tx_busy) begin
         errors++;
         $display("FAIL %s start timeout busy %b need 1", name, tx_busy);
         return;
      end
      if (exp_idle >= 0) begin
         checks++;
         if (idle !== exp_idle) begin
            errors++;
            $display("FAIL %s idle_cycles got %0d need %0d", name, idle, exp_idle);
         end
      end
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL %s underrun_at_start got %b need 0", name, underrun);
      end
      for (int c = 0; c < len; c++) begin
         if (c > 0) @(negedge clk);
         if (scramble && c == 3) begin
            mode     = 2'($urandom);
            rate_sel = 2'($urandom);
         end
         if (!ack) ack_low = 1;
         if (ok_tx) begin
            checks++;
            if (tx_r !== hv[c / p]) begin
               errors++; ok_tx = 0;
               $display("FAIL %s tx cycle %0d got %b need %b", name, c, tx_r, hv[c / p]);
            end
         end
         if (ok_eof) begin
            checks++;
            if (frame_eof !== (c == len - 1)) begin
               errors++; ok_eof = 0;
               $display("FAIL %s frame_eof cycle %0d got %b need %b", name, c,
                        frame_eof, (c == len - 1));
            end
         end
         if (ok_busy) begin
            checks++;
            if (tx_busy !== 1'b1) begin
               errors++; ok_busy = 0;
               $display("FAIL %s tx_busy cycle %0d got %b need 1", name, c, tx_busy);
            end
         end
      end
      checks++;
      if (underrun !== exp_ur) begin
         errors++;
         $display("FAIL %s underrun_at_end got %b need %b", name, underrun, exp_ur);
      end
      $display("frame %s: %0d halves x %0d cycles, idle %0d", name, hv.size(), p, idle);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_r, ack, tx_busy, frame_eof, underrun} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_hold got %b need 01000", {tx_r, ack, tx_busy, frame_eof, underrun});
      end
      RESET = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_r, ack, tx_busy, frame_eof, underrun} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_release got %b need 01000", {tx_r, ack, tx_busy, frame_eof, underrun});
      end
      $display("reset: outputs %b", {tx_r, ack, tx_busy, frame_eof, underrun});
   endtask

   task automatic test_nrz();
      wq_t w = '{9'h1A5};
      mode = 2'b00; rate_sel = 2'd0;
      fork
         writer(w);
         check_frame(model(w, 2'b00), 4, 1'b0, 2, 1'b0, "nrz_a5");
      join
   endtask

   task automatic test_manchester();
      wq_t w = '{9'h10F};
      mode = 2'b01; rate_sel = 2'd3;
      fork
         writer(w);
         check_frame(model(w, 2'b01), 32, 1'b0, 2, 1'b0, "manch_0f");
      join
   endtask

   task automatic test_fm0();
      wq_t w = '{9'h180};
      hq_t hv = '{1,1, 0,0, 1,1, 0,1, 0,1, 0,1, 0,1, 0,1, 0,1, 0,1, 0,0,0,0};
      mode = 2'b10; rate_sel = 2'd0;
      fork
         writer(w);
         check_frame(hv, 4, 1'b0, 2, 1'b0, "fm0_80");
      join
   endtask

   task automatic test_backpressure();
      wq_t w;
      int  busy_after = 0;
      for (int i = 0; i < 6; i++) w.push_back({(i == 5), 8'($urandom)});
      mode = 2'b00; rate_sel = 2'd0;
      ack_low = 0;
      fork
         writer(w);
         check_frame(model(w, 2'b00), 4, 1'b0, 2, 1'b0, "backpressure");
      join
      checks++;
      if (ack_low !== 1'b1) begin
         errors++;
         $display("FAIL backpressure ack_dropped got %b need 1", ack_low);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tx_busy || frame_eof) busy_after++;
      end
      checks++;
      if (busy_after != 0) begin
         errors++;
         $display("FAIL backpressure extra_activity got %0d need 0", busy_after);
      end
   endtask

   task automatic test_underrun();
      wq_t w1 = '{9'h03C};
      wq_t w2 = '{9'h1C3};
      mode = 2'b01; rate_sel = 2'd0;
      fork
         writer(w1);
         check_frame(model(w1, 2'b01), 4, 1'b1, 2, 1'b0, "underrun");
      join
      repeat (5) @(negedge clk);
      checks++;
      if ({underrun, tx_busy} !== 2'b10) begin
         errors++;
         $display("FAIL underrun_sticky got %b need 10", {underrun, tx_busy});
      end
      fork
         writer(w2);
         check_frame(model(w2, 2'b01), 4, 1'b0, 2, 1'b0, "after_underrun");
      join
   endtask

   task automatic test_back_to_back();
      wq_t a = '{9'h05A, 9'h1F0};
      wq_t b = '{9'h013, 9'h1E7};
      mode = 2'b10; rate_sel = 2'd1;
      fork
         writer({a, b});
         begin
            check_frame(model(a, 2'b10), 8, 1'b0, -1, 1'b0, "b2b_first");
            check_frame(model(b, 2'b10), 8, 1'b0, 1, 1'b0, "b2b_second");
         end
      join
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         wq_t        w;
         int         n;
         logic [1:0] m, r;
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) w.push_back({(i == n - 1), 8'($urandom)});
         m = 2'($urandom_range(0, 3));
         r = 2'($urandom_range(0, 2));
         mode = m; rate_sel = r;
         fork
            writer(w);
            check_frame(model(w, m), 4 << r, 1'b0, 2, 1'b1, $sformatf("rand%0d_m%0d_r%0d", it, m, r));
         join
      end
   endtask

   task automatic test_reset_mid();
      wq_t w = '{9'h0E0, 9'h155};
      mode = 2'b00; rate_sel = 2'd0;
      fork
         writer(w);
         begin : wait_start
            int g = 0;
            while (!tx_busy && g < 100) begin
               @(negedge clk);
               g++;
            end
            repeat (34) @(negedge clk);
         end
      join
      checks++;
      if ({tx_busy, tx_r} !== 2'b11) begin
         errors++;
         $display("FAIL reset_mid pre_state got %b need 11", {tx_busy, tx_r});
      end
      #1 RESET = 1'b1;
      #1;
      checks++;
      if ({tx_r, ack, tx_busy, frame_eof, underrun} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_mid async got %b need 01000", {tx_r, ack, tx_busy, frame_eof, underrun});
      end
      $display("reset_mid: outputs %b", {tx_r, ack, tx_busy, frame_eof, underrun});
      @(negedge clk);
      RESET = 1'b0;
      begin : idle_after
         int act = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_busy || frame_eof || !ack) act++;
         end
         checks++;
         if (act != 0) begin
            errors++;
            $display("FAIL reset_mid fifo_discard active_cycles %0d need 0", act);
         end
      end
      begin : after_reset
         wq_t w2 = '{9'h1B6};
         mode = 2'b10; rate_sel = 2'd0;
         fork
            writer(w2);
            check_frame(model(w2, 2'b10), 4, 1'b0, 2, 1'b0, "post_reset");
         join
      end
   endtask

   initial begin
      test_reset();
      test_nrz();
      test_manchester();
      test_fm0();
      test_backpressure();
      test_underrun();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
